// File: rtl/inta_sequencer.sv
// CPU-side interrupt-acknowledge sequencer: synchronises the PIC request, issues the
// two INTA_bar pulses and captures the vector byte presented during the second pulse.
module inta_sequencer #(
   parameter int unsigned PULSE_CYCLES = 4,
   parameter int unsigned GAP_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       reset_bar,
   input  logic       int_req,
   input  logic       int_enable,
   input  logic [7:0] data_bus_in,
   input  logic       vector_ready,
   output logic       INTA_bar,
   output logic [7:0] vector_out,
   output logic       vector_valid,
   output logic       busy
);

   typedef enum logic [1:0] {
      IDLE,
      PULSE1,
      GAP,
      PULSE2
   } state_t;

   localparam logic [7:0] PULSE_LOAD = 8'(PULSE_CYCLES - 1);
   localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       int_meta;
   logic       int_sync;
   logic       start;

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         int_meta <= 1'b0;
         int_sync <= 1'b0;
      end else begin
         int_meta <= int_req;
         int_sync <= int_meta;
      end
   end

   // A pending vector blocks a new sequence unless it is being accepted at this same edge.
   assign start = int_sync && int_enable && (!vector_valid || vector_ready);

   always_ff @(posedge clk or negedge reset_bar) begin
      if (!reset_bar) begin
         state        <= IDLE;
         cnt          <= '0;
         INTA_bar     <= 1'b1;
         vector_out   <= '0;
         vector_valid <= 1'b0;
         busy         <= 1'b0;
      end else begin
         if (vector_valid && vector_ready)
            vector_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= PULSE1;
                  cnt      <= PULSE_LOAD;
                  INTA_bar <= 1'b0;
                  busy     <= 1'b1;
               end
            end
            PULSE1: begin
               if (cnt == 8'd0) begin
                  state    <= GAP;
                  cnt      <= GAP_LOAD;
                  INTA_bar <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            GAP: begin
               if (cnt == 8'd0) begin
                  state    <= PULSE2;
                  cnt      <= PULSE_LOAD;
                  INTA_bar <= 1'b0;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            PULSE2: begin
               if (cnt == 8'd0) begin
                  state        <= IDLE;
                  INTA_bar     <= 1'b1;
                  busy         <= 1'b0;
                  vector_out   <= data_bus_in;
                  vector_valid <= 1'b1;
               end else begin
                  cnt <= cnt - 8'd1;
               end
            end
            default: begin
               state    <= IDLE;
               cnt      <= '0;
               INTA_bar <= 1'b1;
               busy     <= 1'b0;
            end
         endcase
      end
   end

endmodule
